// File: rtl/video_timing_gen_pkg.sv
// Shared types and constants for the video timing generator: the timing record,
// the built-in 640x480@60 default and the legal output-latency range.
package video_timing_pkg;

    localparam int VT_CW       = 12;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;

    // Polarity bits give the asserted level of each sync (1 = active high).
    typedef struct packed {
        logic [VT_CW-1:0] h_sync;
        logic [VT_CW-1:0] h_bp;
        logic [VT_CW-1:0] h_active;
        logic [VT_CW-1:0] h_fp;
        logic [VT_CW-1:0] v_sync;
        logic [VT_CW-1:0] v_bp;
        logic [VT_CW-1:0] v_active;
        logic [VT_CW-1:0] v_fp;
        logic             h_pol;
        logic             v_pol;
    } video_timing_t;

    localparam video_timing_t DEFAULT_TIMING = '{
        h_sync:   12'd96,
        h_bp:     12'd48,
        h_active: 12'd640,
        h_fp:     12'd16,
        v_sync:   12'd2,
        v_bp:     12'd33,
        v_active: 12'd480,
        v_fp:     12'd10,
        h_pol:    1'b0,
        v_pol:    1'b0
    };

endpackage

// File: rtl/video_timing_gen_delayline.sv
// Fixed-length register chain used to align all generator outputs.
// Every stage resets to RST_VAL so outputs show idle levels during reset.
module delayline #(
    parameter int                CYCLES  = 2,
    parameter int                WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [CYCLES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CYCLES; i++) begin
                stage_reg[i] <= RST_VAL;
            end
        end else begin
            stage_reg[0] <= d;
            for (int i = 1; i < CYCLES; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign q = stage_reg[CYCLES-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with frame-boundary timing handshake, field phase and
// optional overlay box hit test (enabled by VIDEO_TIMING_GEN_BOXES_EN).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int            CW        = 12,
    parameter int            NBOX      = 4,
    parameter int            FRAME_DIV = 6,
    parameter int            LATENCY   = 2,
    parameter video_timing_t INIT_TIM  = DEFAULT_TIMING
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  video_timing_t        tim_in,
    input  logic                 tim_valid,
    output logic                 tim_ack,
    input  logic [NBOX*4*CW-1:0] box_in,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [CW-1:0]        pos_x,
    output logic [CW-1:0]        pos_y,
    output logic                 sof,
    output logic                 starttrigger,
    output logic                 field_phase,
    output logic [NBOX-1:0]      box_hit
);

    localparam int            FW     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int            DW     = 7 + 2*CW + NBOX;
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [FW-1:0] F_ONE  = FW'(1);
    localparam logic [FW-1:0] F_LAST = FW'(FRAME_DIV - 1);
    localparam logic [DW-1:0] DL_RST = {~INIT_TIM.h_pol, ~INIT_TIM.v_pol, {(DW-2){1'b0}}};

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("video_timing_gen: LATENCY must be within 1..4");
    end

    video_timing_t  tim_reg;
    logic [CW-1:0]  cx_reg;
    logic [CW-1:0]  cy_reg;
    logic           ack_reg;
    logic [FW-1:0]  fcnt_reg;
    logic           phase_reg;

    // Timing fields widened/narrowed to the counter width.
    logic [CW-1:0] h_sync, h_bp, h_act, h_fp;
    logic [CW-1:0] v_sync, v_bp, v_act, v_fp;
    logic [CW-1:0] h_last, v_last;
    logic [CW-1:0] h_vis_start, h_vis_end, v_vis_start, v_vis_end;

    assign h_sync = CW'(tim_reg.h_sync);
    assign h_bp   = CW'(tim_reg.h_bp);
    assign h_act  = CW'(tim_reg.h_active);
    assign h_fp   = CW'(tim_reg.h_fp);
    assign v_sync = CW'(tim_reg.v_sync);
    assign v_bp   = CW'(tim_reg.v_bp);
    assign v_act  = CW'(tim_reg.v_active);
    assign v_fp   = CW'(tim_reg.v_fp);

    assign h_last      = h_sync + h_bp + h_act + h_fp - ONE;
    assign v_last      = v_sync + v_bp + v_act + v_fp - ONE;
    assign h_vis_start = h_sync + h_bp;
    assign h_vis_end   = h_vis_start + h_act;
    assign v_vis_start = v_sync + v_bp;
    assign v_vis_end   = v_vis_start + v_act;

    logic line_end;
    logic frame_end;

    assign line_end  = (cx_reg == h_last);
    assign frame_end = line_end && (cy_reg == v_last);

    // New timing is only ever swapped in while the counters wrap to (0,0),
    // so a frame never mixes two timings.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cx_reg  <= '0;
            cy_reg  <= '0;
            tim_reg <= INIT_TIM;
            ack_reg <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            if (line_end) begin
                cx_reg <= '0;
                if (frame_end) begin
                    cy_reg <= '0;
                    if (tim_valid) begin
                        tim_reg <= tim_in;
                        ack_reg <= 1'b1;
                    end
                end else begin
                    cy_reg <= cy_reg + ONE;
                end
            end else begin
                cx_reg <= cx_reg + ONE;
            end
        end
    end

    logic          hsync_raw, vsync_raw;
    logic          h_vis, v_vis;
    logic          de_raw, sof_raw;
    logic [CW-1:0] px_raw, py_raw;

    assign hsync_raw = (cx_reg < h_sync) ? tim_reg.h_pol : ~tim_reg.h_pol;
    assign vsync_raw = (cy_reg < v_sync) ? tim_reg.v_pol : ~tim_reg.v_pol;
    assign h_vis     = (cx_reg >= h_vis_start) && (cx_reg < h_vis_end);
    assign v_vis     = (cy_reg >= v_vis_start) && (cy_reg < v_vis_end);
    assign de_raw    = (h_act != '0) && (v_act != '0) && h_vis && v_vis;
    assign sof_raw   = de_raw && (cx_reg == h_vis_start) && (cy_reg == v_vis_start);
    assign px_raw    = de_raw ? (cx_reg - h_vis_start) : '0;
    assign py_raw    = de_raw ? (cy_reg - v_vis_start) : '0;

    logic frame_wrap;
    logic phase_now;
    logic trig_raw;

    // The phase flip is visible on the very sof that causes it.
    assign frame_wrap = sof_raw && (fcnt_reg == F_LAST);
    assign phase_now  = frame_wrap ? ~phase_reg : phase_reg;
    assign trig_raw   = frame_wrap && !phase_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_reg  <= '0;
            phase_reg <= 1'b0;
        end else if (sof_raw) begin
            if (frame_wrap) begin
                fcnt_reg  <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                fcnt_reg  <= fcnt_reg + F_ONE;
            end
        end
    end

    logic [NBOX-1:0] box_raw;

`ifdef VIDEO_TIMING_GEN_BOXES_EN
    logic [NBOX*4*CW-1:0] box_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            box_reg <= '0;
        end else if (frame_end) begin
            box_reg <= box_in;
        end
    end

    // Each box is packed {x0,x1,y0,y1} and is half-open in visible coordinates.
    genvar gi;
    for (gi = 0; gi < NBOX; gi++) begin : g_box
        logic [CW-1:0] x0, x1, y0, y1;
        assign {x0, x1, y0, y1} = box_reg[gi*4*CW +: 4*CW];
        assign box_raw[gi] = de_raw && (px_raw >= x0) && (px_raw < x1)
                                    && (py_raw >= y0) && (py_raw < y1);
    end
`else
    logic unused_box;
    assign unused_box = ^box_in;
    assign box_raw    = '0;
`endif

    logic [DW-1:0] dl_d;
    logic [DW-1:0] dl_q;

    assign dl_d = {hsync_raw, vsync_raw, de_raw, sof_raw, trig_raw, phase_now,
                   ack_reg, px_raw, py_raw, box_raw};

    delayline #(
        .CYCLES  (LATENCY),
        .WIDTH   (DW),
        .RST_VAL (DL_RST)
    ) u_align (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (dl_d),
        .q       (dl_q)
    );

    assign {hsync, vsync, de, sof, starttrigger, field_phase,
            tim_ack, pos_x, pos_y, box_hit} = dl_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: one instance on the 640x480 default,
// one started on a tiny raster so handshake and field-phase runs stay short.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int CW   = 12;
    localparam int NBOX = 4;

    // T0: 15 x 8 total, visible 8 x 4 at (5,3), negative syncs.
    localparam video_timing_t T0 = '{h_sync: 12'd2, h_bp: 12'd3, h_active: 12'd8, h_fp: 12'd2,
                                     v_sync: 12'd1, v_bp: 12'd2, v_active: 12'd4, v_fp: 12'd1,
                                     h_pol: 1'b0, v_pol: 1'b0};
    // T1: 30 x 14 total, visible 24 x 9 at (5,3), positive syncs.
    localparam video_timing_t T1 = '{h_sync: 12'd3, h_bp: 12'd2, h_active: 12'd24, h_fp: 12'd1,
                                     v_sync: 12'd2, v_bp: 12'd1, v_active: 12'd9, v_fp: 12'd2,
                                     h_pol: 1'b1, v_pol: 1'b1};
    // T2: 6 x 6 total with no visible columns.
    localparam video_timing_t T2 = '{h_sync: 12'd2, h_bp: 12'd2, h_active: 12'd0, h_fp: 12'd2,
                                     v_sync: 12'd1, v_bp: 12'd1, v_active: 12'd3, v_fp: 12'd1,
                                     h_pol: 1'b0, v_pol: 1'b0};

`ifdef VIDEO_TIMING_GEN_BOXES_EN
    localparam int BOX_EXP = 20;
`else
    localparam int BOX_EXP = 0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset_n;
    video_timing_t        tim_in;
    logic                 tim_valid;
    logic [NBOX*4*CW-1:0] box_in;
    logic                 tim_ack, hsync, vsync, de, sof, starttrigger, field_phase;
    logic [CW-1:0]        pos_x, pos_y;
    logic [NBOX-1:0]      box_hit;

    video_timing_t        d_tim_in;
    logic                 d_tim_valid;
    logic [NBOX*4*CW-1:0] d_box_in;
    logic                 d_tim_ack, d_hsync, d_vsync, d_de, d_sof, d_starttrigger, d_field_phase;
    logic [CW-1:0]        d_pos_x, d_pos_y;
    logic [NBOX-1:0]      d_box_hit;

    int passed = 0;
    int total  = 0;

    video_timing_gen #(.CW(CW), .NBOX(NBOX), .FRAME_DIV(6), .LATENCY(2), .INIT_TIM(T0)) dut (
        .clock(clock), .reset_n(reset_n), .tim_in(tim_in), .tim_valid(tim_valid),
        .tim_ack(tim_ack), .box_in(box_in), .hsync(hsync), .vsync(vsync), .de(de),
        .pos_x(pos_x), .pos_y(pos_y), .sof(sof), .starttrigger(starttrigger),
        .field_phase(field_phase), .box_hit(box_hit)
    );

    video_timing_gen dut_def (
        .clock(clock), .reset_n(reset_n), .tim_in(d_tim_in), .tim_valid(d_tim_valid),
        .tim_ack(d_tim_ack), .box_in(d_box_in), .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
        .pos_x(d_pos_x), .pos_y(d_pos_y), .sof(d_sof), .starttrigger(d_starttrigger),
        .field_phase(d_field_phase), .box_hit(d_box_hit)
    );

    // Leaves reset released at a negedge; the next negedge is cycle 1.
    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        total++; if (d_hsync !== 1'b1) $display("FAIL reset_d_hsync: got %b expected 1", d_hsync); else passed++;
        total++; if (d_vsync !== 1'b1) $display("FAIL reset_d_vsync: got %b expected 1", d_vsync); else passed++;
        total++; if ({d_de, d_sof, d_starttrigger, d_tim_ack, d_field_phase} !== 5'b0)
            $display("FAIL reset_d_ctrl: got %b expected 00000", {d_de, d_sof, d_starttrigger, d_tim_ack, d_field_phase}); else passed++;
        total++; if ({d_pos_x, d_pos_y} !== '0) $display("FAIL reset_d_pos: got %0d,%0d expected 0,0", d_pos_x, d_pos_y); else passed++;
        total++; if ({hsync, vsync} !== 2'b11) $display("FAIL reset_sync: got %b expected 11", {hsync, vsync}); else passed++;
        total++; if (box_hit !== '0) $display("FAIL reset_box: got %b expected 0", box_hit); else passed++;
        $display("test_reset: checked idle outputs of both instances");
    endtask

    task automatic test_default_timing();
        int hs_fall1 = 0, hs_fall2 = 0, hs_rise1 = 0, vs_fall = 0, vs_rise = 0;
        int sof_k = 0, de_before = 0, de_line = 0;
        logic [CW-1:0] px_sof = '1, py_sof = '1, px_last = '0, px_after = '1;
        logic de_after = 1'b1;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        reset_n = 1'b1;
        for (int k = 1; k <= 28146 + 800; k++) begin
            @(negedge clock);
            if (prev_hs && !d_hsync) begin
                if (hs_fall1 == 0) hs_fall1 = k; else if (hs_fall2 == 0) hs_fall2 = k;
            end
            if (!prev_hs && d_hsync && hs_rise1 == 0) hs_rise1 = k;
            if (prev_vs && !d_vsync && vs_fall == 0) vs_fall = k;
            if (!prev_vs && d_vsync && vs_rise == 0) vs_rise = k;
            if (d_sof && sof_k == 0) begin sof_k = k; px_sof = d_pos_x; py_sof = d_pos_y; end
            if (d_de) begin
                if (sof_k == 0) de_before++; else if (k < sof_k + 800) de_line++;
            end
            if (sof_k != 0 && k == sof_k + 639) px_last = d_pos_x;
            if (sof_k != 0 && k == sof_k + 640) begin px_after = d_pos_x; de_after = d_de; end
            prev_hs = d_hsync;
            prev_vs = d_vsync;
        end
        total++; if (hs_fall1 != 2) $display("FAIL def_latency: got hsync fall at %0d expected 2", hs_fall1); else passed++;
        total++; if (hs_rise1 != 98) $display("FAIL def_hsync_width: got rise at %0d expected 98", hs_rise1); else passed++;
        total++; if (hs_fall2 != 802) $display("FAIL def_hsync_period: got fall at %0d expected 802", hs_fall2); else passed++;
        total++; if (vs_fall != 2 || vs_rise != 1602) $display("FAIL def_vsync: got %0d..%0d expected 2..1602", vs_fall, vs_rise); else passed++;
        total++; if (sof_k != 28146) $display("FAIL def_sof_time: got %0d expected 28146", sof_k); else passed++;
        total++; if (px_sof !== 0 || py_sof !== 0) $display("FAIL def_sof_pos: got %0d,%0d expected 0,0", px_sof, py_sof); else passed++;
        total++; if (de_before != 0) $display("FAIL def_de_early: got %0d expected 0", de_before); else passed++;
        total++; if (de_line != 640) $display("FAIL def_de_line: got %0d expected 640", de_line); else passed++;
        total++; if (px_last !== 639) $display("FAIL def_last_x: got %0d expected 639", px_last); else passed++;
        total++; if (px_after !== 0 || de_after !== 1'b0) $display("FAIL def_blank_pos: got x=%0d de=%b expected 0,0", px_after, de_after); else passed++;
        $display("test_default_timing: sof at cycle %0d, %0d visible pixels on first line", sof_k, de_line);
    endtask

    task automatic test_handshake();
        int ack_k = 0, ack_cnt = 0, de_old = 0, de_new = 0, hs_act = 0, vs_act = 0;
        int box_cnt = 0, box_bad = 0, sof_k = 0, hs_r1 = 0, hs_r2 = 0;
        logic [CW-1:0] px_sof = '1, py_sof = '1;
        logic prev_hs = 1'b1;
        box_in = '0;
        box_in[47:0] = {12'd10, 12'd20, 12'd5, 12'd7};
        do_reset();
        for (int k = 1; k <= 560; k++) begin
            @(negedge clock);
            if (tim_ack) begin ack_cnt++; if (ack_k == 0) ack_k = k; tim_valid = 1'b0; end
            if (k < 122 && de) de_old++;
            if (k >= 122 && k < 542) begin
                if (de) de_new++;
                if (hsync) hs_act++;
                if (vsync) vs_act++;
                if (box_hit[0]) begin
                    box_cnt++;
                    if (!(pos_x >= 10 && pos_x <= 19 && pos_y >= 5 && pos_y <= 6)) box_bad++;
                end
                if (|box_hit[3:1]) box_bad++;
                if (sof && sof_k == 0) begin sof_k = k; px_sof = pos_x; py_sof = pos_y; end
                if (!prev_hs && hsync) begin
                    if (hs_r1 == 0) hs_r1 = k; else if (hs_r2 == 0) hs_r2 = k;
                end
            end
            prev_hs = hsync;
            if (k == 30) begin tim_in = T1; tim_valid = 1'b1; end
        end
        total++; if (ack_k != 122) $display("FAIL hs_ack_time: got %0d expected 122", ack_k); else passed++;
        total++; if (ack_cnt != 1) $display("FAIL hs_ack_count: got %0d expected 1", ack_cnt); else passed++;
        total++; if (de_old != 32) $display("FAIL hs_old_frame_de: got %0d expected 32", de_old); else passed++;
        total++; if (de_new != 216) $display("FAIL hs_new_frame_de: got %0d expected 216", de_new); else passed++;
        total++; if (hs_act != 42 || vs_act != 60) $display("FAIL hs_new_sync: got %0d/%0d expected 42/60", hs_act, vs_act); else passed++;
        total++; if (hs_r2 - hs_r1 != 30) $display("FAIL hs_new_htotal: got %0d expected 30", hs_r2 - hs_r1); else passed++;
        total++; if (sof_k - 122 != 95 || px_sof !== 0 || py_sof !== 0)
            $display("FAIL hs_new_sof: got offset %0d pos %0d,%0d expected 95 pos 0,0", sof_k - 122, px_sof, py_sof); else passed++;
        total++; if (box_cnt != BOX_EXP) $display("FAIL box_count: got %0d expected %0d", box_cnt, BOX_EXP); else passed++;
        total++; if (box_bad != 0) $display("FAIL box_outside: got %0d expected 0", box_bad); else passed++;
        $display("test_handshake: ack at cycle %0d, new frame de=%0d box hits=%0d", ack_k, de_new, box_cnt);
    endtask

    task automatic test_cancel();
        int ack_cnt = 0, de_cnt = 0, hs_cnt = 0;
        tim_in = T2;
        tim_valid = 1'b1;
        repeat (50) begin
            @(negedge clock);
            if (tim_ack) ack_cnt++;
        end
        tim_valid = 1'b0;
        for (int k = 0; k < 840; k++) begin
            @(negedge clock);
            if (tim_ack) ack_cnt++;
            if (de) de_cnt++;
            if (hsync) hs_cnt++;
        end
        total++; if (ack_cnt != 0) $display("FAIL cancel_ack: got %0d expected 0", ack_cnt); else passed++;
        total++; if (de_cnt != 432 || hs_cnt != 84) $display("FAIL cancel_timing_kept: got de=%0d hs=%0d expected 432/84", de_cnt, hs_cnt); else passed++;
        $display("test_cancel: withdrawn request, %0d acks", ack_cnt);
    endtask

    task automatic test_field_phase();
        int sof_n = 0, trig_n = 0, trig_stray = 0;
        logic exp_ph, exp_tr;
        do_reset();
        for (int k = 1; k <= 3662; k++) begin
            @(negedge clock);
            if (starttrigger && !sof) trig_stray++;
            if (sof) begin
                sof_n++;
                exp_ph = ((sof_n / 6) % 2) == 1;
                exp_tr = (sof_n % 12) == 6;
                if (starttrigger) trig_n++;
                total++; if (field_phase !== exp_ph) $display("FAIL phase_frame%0d: got %b expected %b", sof_n, field_phase, exp_ph); else passed++;
                total++; if (starttrigger !== exp_tr) $display("FAIL trig_frame%0d: got %b expected %b", sof_n, starttrigger, exp_tr); else passed++;
            end
        end
        total++; if (sof_n != 31) $display("FAIL phase_sof_count: got %0d expected 31", sof_n); else passed++;
        total++; if (trig_n != 3 || trig_stray != 0) $display("FAIL trig_count: got %0d stray %0d expected 3 stray 0", trig_n, trig_stray); else passed++;
        $display("test_field_phase: %0d frames, %0d start triggers", sof_n, trig_n);
    endtask

    task automatic test_no_active();
        logic got = 1'b0;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        int hs_low = 0, vs_low = 0, hs_falls = 0, vs_falls = 0, active = 0;
        tim_in = T2;
        tim_valid = 1'b1;
        for (int w = 0; w < 300 && !got; w++) begin
            @(negedge clock);
            if (tim_ack) got = 1'b1;
        end
        tim_valid = 1'b0;
        total++; if (!got) $display("FAIL noact_ack_timeout: got no ack expected ack within 300 cycles"); else passed++;
        for (int j = 0; j < 72; j++) begin
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (prev_hs && !hsync) hs_falls++;
            if (prev_vs && !vsync) vs_falls++;
            if (de || sof || starttrigger || (|box_hit)) active++;
            prev_hs = hsync;
            prev_vs = vsync;
            @(negedge clock);
        end
        total++; if (active != 0) $display("FAIL noact_de: got %0d active cycles expected 0", active); else passed++;
        total++; if (hs_low != 24 || hs_falls != 12) $display("FAIL noact_hsync: got low=%0d falls=%0d expected 24/12", hs_low, hs_falls); else passed++;
        total++; if (vs_low != 12 || vs_falls != 2) $display("FAIL noact_vsync: got low=%0d falls=%0d expected 12/2", vs_low, vs_falls); else passed++;
        $display("test_no_active: %0d hsync pulses, %0d vsync pulses over two frames", hs_falls, vs_falls);
    endtask

    task automatic test_reset_midline();
        int ack_k = 0, ack_rst = 0, de_old = 0, hs_first_low = 0;
        tim_in = T1;
        tim_valid = 1'b1;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        total++; if ({hsync, vsync} !== 2'b11) $display("FAIL rst_mid_sync: got %b expected 11", {hsync, vsync}); else passed++;
        total++; if ({de, sof, tim_ack, field_phase} !== 4'b0 || {pos_x, pos_y} !== '0)
            $display("FAIL rst_mid_outputs: got ctrl=%b pos=%0d,%0d expected 0", {de, sof, tim_ack, field_phase}, pos_x, pos_y); else passed++;
        repeat (3) begin
            @(negedge clock);
            if (tim_ack) ack_rst++;
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clock);
            if (tim_ack) begin if (ack_k == 0) ack_k = k; tim_valid = 1'b0; end
            if (k < 122 && de) de_old++;
            if (!hsync && hs_first_low == 0) hs_first_low = k;
        end
        total++; if (ack_rst != 0) $display("FAIL rst_mid_no_ack: got %0d expected 0", ack_rst); else passed++;
        total++; if (ack_k != 122) $display("FAIL rst_mid_ack_time: got %0d expected 122", ack_k); else passed++;
        total++; if (de_old != 32 || hs_first_low != 2) $display("FAIL rst_mid_default: got de=%0d hs_low_at=%0d expected 32/2", de_old, hs_first_low); else passed++;
        $display("test_reset_midline: restart on default timing, ack at cycle %0d", ack_k);
    endtask

    initial begin
        reset_n     = 1'b0;
        tim_in      = T0;
        tim_valid   = 1'b0;
        box_in      = '0;
        d_tim_in    = DEFAULT_TIMING;
        d_tim_valid = 1'b0;
        d_box_in    = '0;
        test_reset();
        test_default_timing();
        test_handshake();
        test_cancel();
        test_field_phase();
        test_no_active();
        test_reset_midline();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
